// File: rtl/stream_feeder.sv
// Transmit-side operand source for one systolic array row/column: buffers a
// DEPTH-word vector and, after START_DELAY idle cycles, streams it out once per start.
module stream_feeder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int START_DELAY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     start,
    output logic                     out_data_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    localparam logic [7:0]       DLY_M1   = (START_DELAY > 0) ? 8'(START_DELAY - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, DELAY, STREAM, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  buf_q [DEPTH];
    logic              wr_ok;

    // Buffer only changes while fully idle, so a stream always sees a stable vector.
    assign wr_ok = wr_en && (state_q == IDLE) && !start && ({1'b0, wr_addr} < DEPTH_L);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_ok) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic computes the outputs for the following cycle, so every output is a flop.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (START_DELAY == 0) begin
                        state_d = STREAM;
                        valid_d = 1'b1;
                        data_d  = buf_q[0];
                        idx_d   = AW'(1);
                    end else begin
                        state_d = DELAY;
                        cnt_d   = DLY_M1;
                    end
                end
            end
            DELAY: begin
                busy_d = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = STREAM;
                    valid_d = 1'b1;
                    data_d  = buf_q[0];
                    idx_d   = AW'(1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STREAM: begin
                busy_d = 1'b1;
                if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end else begin
                    valid_d = 1'b1;
                    data_d  = buf_q[idx_q];
                    last_d  = (idx_q == LAST_IDX);
                    idx_d   = idx_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_data_valid = valid_q;
    assign out_data       = data_q;
    assign out_last       = last_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_stream_feeder.sv
// Directed bench for stream_feeder: one instance with no start delay, one with a delay of 3.
module tb_stream_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;

    logic        v0, l0, b0, dn0;
    logic [31:0] dat0;
    logic        v3, l3, b3, dn3;
    logic [31:0] dat3;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [127:0] VEC_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] VEC_Z = 128'h0;
    localparam logic [127:0] VEC_B = {32'h88, 32'h77, 32'h66, 32'h55};

    always #5 clk = ~clk;

    stream_feeder #(.WIDTH(32), .DEPTH(4), .START_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .out_data_valid(v0), .out_data(dat0), .out_last(l0),
        .busy(b0), .done(dn0)
    );

    stream_feeder #(.WIDTH(32), .DEPTH(4), .START_DELAY(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .out_data_valid(v3), .out_data(dat3), .out_last(l3),
        .busy(b3), .done(dn3)
    );

    function automatic logic [35:0] obs0();
        return {v0, l0, b0, dn0, dat0};
    endfunction

    function automatic logic [35:0] obs3();
        return {v3, l3, b3, dn3, dat3};
    endfunction

    // Expected {valid,last,busy,done,data} in the n-th cycle after the start edge.
    function automatic logic [35:0] model(int d, int n, logic [127:0] w);
        int i;
        if (n <= d) return {4'b0010, 32'h0};
        i = n - 1 - d;
        if (i < 4) return {1'b1, (i == 3), 1'b1, 1'b0, w[i*32 +: 32]};
        if (i == 4) return {4'b0011, 32'h0};
        return 36'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_word(logic [1:0] a, logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if (obs0() !== 36'h0) $display("FAIL reset_d0 got=%h exp=%h", obs0(), 36'h0);
        else pass_cnt++;
        total_cnt++;
        if (obs3() !== 36'h0) $display("FAIL reset_d3 got=%h exp=%h", obs3(), 36'h0);
        else pass_cnt++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_stream_d0();
        logic [35:0] exp;
        write_word(2'd0, 32'h11);
        write_word(2'd1, 32'h22);
        write_word(2'd2, 32'h33);
        write_word(2'd3, 32'h44);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step();
            exp = model(0, n, VEC_A);
            total_cnt++;
            if (obs0() !== exp) $display("FAIL stream_d0 n=%0d got=%h exp=%h", n, obs0(), exp);
            else pass_cnt++;
        end
        idle(4);
    endtask

    task automatic test_stream_d3();
        logic [35:0] exp;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            if (n > 1) step();
            exp = model(3, n, VEC_A);
            total_cnt++;
            if (obs3() !== exp) $display("FAIL stream_d3 n=%0d got=%h exp=%h", n, obs3(), exp);
            else pass_cnt++;
        end
        idle(2);
    endtask

    task automatic test_write_during_stream();
        logic [35:0] exp;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step();
            exp = model(0, n, VEC_A);
            total_cnt++;
            if (obs0() !== exp) $display("FAIL wr_busy n=%0d got=%h exp=%h", n, obs0(), exp);
            else pass_cnt++;
            if (n == 2) begin
                wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hFF; start = 1'b1;
            end else begin
                wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
            end
        end
        idle(4);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step();
            exp = model(0, n, VEC_A);
            total_cnt++;
            if (obs0() !== exp) $display("FAIL wr_busy_restream n=%0d got=%h exp=%h", n, obs0(), exp);
            else pass_cnt++;
        end
        idle(4);
    endtask

    task automatic test_write_with_start();
        logic [35:0] exp;
        for (int r = 0; r < 2; r++) begin
            start = 1'b1;
            if (r == 0) begin
                wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'hAA;
            end
            step();
            start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
            for (int n = 1; n <= 6; n++) begin
                if (n > 1) step();
                exp = model(0, n, VEC_A);
                total_cnt++;
                if (obs0() !== exp) $display("FAIL wr_start r=%0d n=%0d got=%h exp=%h", r, n, obs0(), exp);
                else pass_cnt++;
            end
            idle(4);
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] exp;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            if (n > 1) step();
            exp = model(0, n, VEC_A);
            total_cnt++;
            if (obs0() !== exp) $display("FAIL rst_mid_pre n=%0d got=%h exp=%h", n, obs0(), exp);
            else pass_cnt++;
        end
        rst = 1'b0;
        #1;
        total_cnt++;
        if (obs0() !== 36'h0) $display("FAIL rst_async_d0 got=%h exp=%h", obs0(), 36'h0);
        else pass_cnt++;
        total_cnt++;
        if (obs3() !== 36'h0) $display("FAIL rst_async_d3 got=%h exp=%h", obs3(), 36'h0);
        else pass_cnt++;
        step();
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            total_cnt++;
            if (obs0() !== 36'h0) $display("FAIL rst_no_done n=%0d got=%h exp=%h", n, obs0(), 36'h0);
            else pass_cnt++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step();
            exp = model(0, n, VEC_Z);
            total_cnt++;
            if (obs0() !== exp) $display("FAIL rst_cleared n=%0d got=%h exp=%h", n, obs0(), exp);
            else pass_cnt++;
        end
        idle(4);
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp;
        write_word(2'd0, 32'h55);
        write_word(2'd1, 32'h66);
        write_word(2'd2, 32'h77);
        write_word(2'd3, 32'h88);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step();
            exp = model(0, n, VEC_B);
            total_cnt++;
            if (obs0() !== exp) $display("FAIL b2b_first n=%0d got=%h exp=%h", n, obs0(), exp);
            else pass_cnt++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step();
            exp = model(0, n, VEC_B);
            total_cnt++;
            if (obs0() !== exp) $display("FAIL b2b_second n=%0d got=%h exp=%h", n, obs0(), exp);
            else pass_cnt++;
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_stream_d0();
        test_stream_d3();
        test_write_during_stream();
        test_write_with_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
